move_eval_sequencer: RTL and testbench

Hardware sequencer for the TPU's per-move evaluation loop. It walks move indices 0..N-1 through the grid decoder, runs the configured number of DNN layers per move on the unified buffer and systolic array, and tracks the signed argmax of the final-layer score. It then emits the winning 16-bit move code as two bytes on the SPI output path. It takes over the loop that the instruction stream otherwise drives through the register file, so layer programming stays in software and move iteration moves into hardware.

---
 rtl/move_eval_sequencer_if.sv | 44 ++++
 rtl/move_eval_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_move_eval_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/move_eval_sequencer_if.sv
// Handshake bundle between the move evaluation sequencer and the surrounding TPU datapath.
//
// master : the sequencer side (drives grid/layer requests, SPI bytes and status)
// slave  : the datapath / environment side (drives start, grid, layer and score responses)
//
// Signals:
//   moves_iv, total_move_id        start pulse and requested move count
//   compute_grid, move_num         grid build request for the current move index
//   grid_iv, current_move_id       grid built, move code of the current grid
//   layer_start, layer_idx         layer launch pulse and layer index
//   layer_done                     layer result landed in the buffer
//   dnn_iv, dnn_id                 final signed score
//   spi_ov, spi_od                 output byte stream
//   busy, error                    status
interface move_eval_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MOVE_WIDTH = 16
);
    logic                  moves_iv;
    logic [7:0]            total_move_id;
    logic                  compute_grid;
    logic [7:0]            move_num;
    logic                  grid_iv;
    logic [MOVE_WIDTH-1:0] current_move_id;
    logic                  layer_start;
    logic [3:0]            layer_idx;
    logic                  layer_done;
    logic                  dnn_iv;
    logic [DATA_WIDTH-1:0] dnn_id;
    logic                  spi_ov;
    logic [DATA_WIDTH-1:0] spi_od;
    logic                  busy;
    logic                  error;

    modport master (
        input  moves_iv, total_move_id, grid_iv, current_move_id, layer_done, dnn_iv, dnn_id,
        output compute_grid, move_num, layer_start, layer_idx, spi_ov, spi_od, busy, error
    );

    modport slave (
        output moves_iv, total_move_id, grid_iv, current_move_id, layer_done, dnn_iv, dnn_id,
        input  compute_grid, move_num, layer_start, layer_idx, spi_ov, spi_od, busy, error
    );
endinterface

// File: rtl/move_eval_sequencer.sv
// Per-move evaluation sequencer: walks move indices through the grid decoder, runs NUM_LAYERS
// DNN layers per move, keeps the signed argmax of the final score and ships the winning move
// code out as two SPI bytes (high byte first).
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   move_eval_sequencer_if.master (start, grid, layer, score, SPI and status signals)
//
// Optional feature: define MOVE_EVAL_TIMEOUT_EN to enable a per-wait-state watchdog that flags
// error and skips the stalled move after TIMEOUT_CYCLES cycles. Without it the wait states block
// indefinitely and error is tied low.
module move_eval_sequencer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MOVE_WIDTH     = 16,
    parameter int unsigned MAX_MOVES      = 220,
    parameter int unsigned NUM_LAYERS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                   clk,
    input logic                   rst,
    move_eval_sequencer_if.master bus
);

    localparam logic [7:0] MaxMoves  = 8'(MAX_MOVES);
    localparam logic [3:0] LastLayer = 4'(NUM_LAYERS - 1);

    typedef enum logic [3:0] {
        StIdle,
        StReqGrid,
        StWaitGrid,
        StStartLayer,
        StWaitLayer,
        StWaitScore,
        StNextMove,
        StSendHi,
        StSendLo
    } state_e;

    state_e                        state_q, state_d;
    logic   [7:0]                  count_q;
    logic   [7:0]                  move_num_q;
    logic   [3:0]                  layer_idx_q;
    logic   [MOVE_WIDTH-1:0]       cur_move_q;
    logic                          score_seen_q;
    logic                          best_valid_q;
    logic   signed [DATA_WIDTH-1:0] best_score_q;
    logic   [MOVE_WIDTH-1:0]       best_move_q;

    logic                  compute_grid_q;
    logic                  layer_start_q;
    logic                  spi_ov_q;
    logic [DATA_WIDTH-1:0] spi_od_q;
    logic                  busy_q;

    logic       start_ok;
    logic [7:0] count_new;
    logic       last_layer;
    logic       more_moves;
    logic       take_score;
    logic       timeout;

`ifdef MOVE_EVAL_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_q;
    logic        error_q;
    logic        in_wait;
`endif

    always_comb begin
        state_d    = state_q;
        take_score = 1'b0;
        timeout    = 1'b0;
        start_ok   = (state_q == StIdle) && bus.moves_iv;
        count_new  = (bus.total_move_id > MaxMoves) ? MaxMoves : bus.total_move_id;
        last_layer = (layer_idx_q == LastLayer);
        more_moves = ({1'b0, move_num_q} + 9'd1) < {1'b0, count_q};

        unique case (state_q)
            StIdle: begin
                if (bus.moves_iv) begin
                    state_d = (count_new == 8'd0) ? StSendHi : StReqGrid;
                end
            end
            StReqGrid:    state_d = StWaitGrid;
            StWaitGrid:   if (bus.grid_iv) state_d = StStartLayer;
            StStartLayer: state_d = StWaitLayer;
            StWaitLayer: begin
                // The score may beat the last layer_done; only the first one per move counts.
                take_score = last_layer && bus.dnn_iv && !score_seen_q;
                if (bus.layer_done) begin
                    if (!last_layer)                      state_d = StStartLayer;
                    else if (score_seen_q || take_score) state_d = StNextMove;
                    else                                  state_d = StWaitScore;
                end
            end
            StWaitScore: begin
                if (bus.dnn_iv) begin
                    take_score = !score_seen_q;
                    state_d    = StNextMove;
                end
            end
            StNextMove: state_d = more_moves ? StReqGrid : StSendHi;
            StSendHi:   state_d = StSendLo;
            StSendLo:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase

`ifdef MOVE_EVAL_TIMEOUT_EN
        in_wait = state_q inside {StWaitGrid, StWaitLayer, StWaitScore};
        // Watchdog only fires when no real event moved the FSM this cycle.
        if (in_wait && (state_d == state_q) && (wait_cnt_q == TimeoutLast)) begin
            timeout    = 1'b1;
            take_score = 1'b0;
            state_d    = StNextMove;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            count_q        <= '0;
            move_num_q     <= '0;
            layer_idx_q    <= '0;
            cur_move_q     <= '0;
            score_seen_q   <= 1'b0;
            best_valid_q   <= 1'b0;
            best_score_q   <= '0;
            best_move_q    <= '0;
            compute_grid_q <= 1'b0;
            layer_start_q  <= 1'b0;
            spi_ov_q       <= 1'b0;
            spi_od_q       <= '0;
            busy_q         <= 1'b0;
`ifdef MOVE_EVAL_TIMEOUT_EN
            wait_cnt_q     <= '0;
            error_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;

            if (start_ok) begin
                count_q      <= count_new;
                move_num_q   <= '0;
                layer_idx_q  <= '0;
                score_seen_q <= 1'b0;
                best_valid_q <= 1'b0;
                best_score_q <= '0;
                best_move_q  <= '0;
            end

            if ((state_q == StWaitGrid) && bus.grid_iv) begin
                cur_move_q <= bus.current_move_id;
            end

            if ((state_q == StWaitLayer) && bus.layer_done && !last_layer) begin
                layer_idx_q <= layer_idx_q + 4'd1;
            end

            if ((state_q == StNextMove) && more_moves) begin
                move_num_q   <= move_num_q + 8'd1;
                layer_idx_q  <= '0;
                score_seen_q <= 1'b0;
            end

            // Strict compare keeps the lowest move index on ties.
            if (take_score) begin
                score_seen_q <= 1'b1;
                if (!best_valid_q || ($signed(bus.dnn_id) > best_score_q)) begin
                    best_valid_q <= 1'b1;
                    best_score_q <= $signed(bus.dnn_id);
                    best_move_q  <= cur_move_q;
                end
            end

`ifdef MOVE_EVAL_TIMEOUT_EN
            if (state_d != state_q) begin
                wait_cnt_q <= '0;
            end else if (in_wait) begin
                wait_cnt_q <= wait_cnt_q + 16'd1;
            end
            if (start_ok) begin
                error_q <= 1'b0;
            end else if (timeout) begin
                error_q <= 1'b1;
            end
`endif

            // Outputs are registered from the next state so they line up with state_q.
            compute_grid_q <= (state_d == StReqGrid);
            layer_start_q  <= (state_d == StStartLayer);
            busy_q         <= (state_d != StIdle);
            spi_ov_q       <= (state_d == StSendHi) || (state_d == StSendLo);
            // A zero-count start jumps straight to SEND_HI while best_move_q is still stale.
            if ((state_d == StSendHi) && !start_ok) begin
                spi_od_q <= best_move_q[MOVE_WIDTH-1:DATA_WIDTH];
            end else if (state_d == StSendLo) begin
                spi_od_q <= best_move_q[DATA_WIDTH-1:0];
            end else begin
                spi_od_q <= '0;
            end
        end
    end

    assign bus.compute_grid = compute_grid_q;
    assign bus.move_num     = move_num_q;
    assign bus.layer_start  = layer_start_q;
    assign bus.layer_idx    = layer_idx_q;
    assign bus.spi_ov       = spi_ov_q;
    assign bus.spi_od       = spi_od_q;
    assign bus.busy         = busy_q;
`ifdef MOVE_EVAL_TIMEOUT_EN
    assign bus.error        = error_q;
`else
    assign bus.error        = 1'b0;
`endif

endmodule

// File: tb/tb_move_eval_sequencer.sv
// Directed bench for move_eval_sequencer with a byte scoreboard on the SPI output.
module tb_move_eval_sequencer;

    localparam int NL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    move_eval_sequencer_if #(.DATA_WIDTH(8), .MOVE_WIDTH(16)) bus ();

    move_eval_sequencer #(
        .DATA_WIDTH(8),
        .MOVE_WIDTH(16),
        .MAX_MOVES(220),
        .NUM_LAYERS(NL),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_grid   = 0;
    int n_layer  = 0;
    int grid_idx = 0;
    logic [7:0] sb[$];

    // Reference argmax model
    logic              m_valid;
    logic signed [7:0] m_score;
    logic [15:0]       m_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and pulse monitors
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.spi_ov) begin
                check("spi_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("spi_byte", bus.spi_od, sb.pop_front());
            end
            if (bus.compute_grid) begin
                check("move_num_seq", bus.move_num, grid_idx);
                grid_idx++;
                n_grid++;
            end
            if (bus.layer_start) n_layer++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic wait_grid_req();
        int n = 0;
        while (bus.compute_grid !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        check("compute_grid_wait", bus.compute_grid, 1);
    endtask

    task automatic start_run(input logic [7:0] total);
        m_valid  = 1'b0;
        m_score  = '0;
        m_code   = '0;
        grid_idx = 0;
        bus.moves_iv      = 1'b1;
        bus.total_move_id = total;
        cyc();
        bus.moves_iv = 1'b0;
        check("busy_after_start", bus.busy, 1);
        check("grid_after_start", bus.compute_grid, 32'(total != 0));
    endtask

    // mode 0: score with last layer_done, 1: score in WAIT_SCORE,
    // 2: score 3 cycles early plus an ignored 127, 3: no grid_iv (watchdog)
    task automatic do_move(input logic [15:0] code, input logic [7:0] score, input int mode);
        wait_grid_req();
        cyc();
        bus.moves_iv = 1'b0;
        if (mode == 3) return;
        bus.grid_iv = 1'b1;
        bus.current_move_id = code;
        cyc();
        bus.grid_iv = 1'b0;
        for (int l = 0; l < NL; l++) begin
            check("layer_start", bus.layer_start, 1);
            check("layer_idx", bus.layer_idx, l);
            cyc();
            if (l == NL - 1 && mode == 2) begin
                bus.dnn_iv = 1'b1;
                bus.dnn_id = score;
                cyc();
                bus.dnn_id = 8'h7f;
                cyc();
                bus.dnn_iv = 1'b0;
                cyc();
            end
            bus.layer_done = 1'b1;
            if (l == NL - 1 && mode == 0) begin
                bus.dnn_iv = 1'b1;
                bus.dnn_id = score;
            end
            cyc();
            bus.layer_done = 1'b0;
            bus.dnn_iv     = 1'b0;
            if (l == NL - 1 && mode == 1) begin
                bus.dnn_iv = 1'b1;
                bus.dnn_id = score;
                cyc();
                bus.dnn_iv = 1'b0;
            end
        end
        if (!m_valid || $signed(score) > m_score) begin
            m_valid = 1'b1;
            m_score = $signed(score);
            m_code  = code;
        end
    endtask

    task automatic finish_run(input bit already_hi);
        sb.push_back(m_code[15:8]);
        sb.push_back(m_code[7:0]);
        if (!already_hi) cyc();
        check("send_hi_timing", bus.spi_ov, 1);
        cyc();
        check("send_lo_timing", bus.spi_ov, 1);
        cyc();
        check("idle_after_send", bus.busy, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int g0, l0;
        bus.moves_iv = 1'b0;
        bus.total_move_id = '0;
        bus.grid_iv = 1'b0;
        bus.current_move_id = '0;
        bus.layer_done = 1'b0;
        bus.dnn_iv = 1'b0;
        bus.dnn_id = '0;

        // Reset state
        repeat (3) cyc();
        check("rst_busy", bus.busy, 0);
        check("rst_outputs", {bus.compute_grid, bus.layer_start, bus.spi_ov, bus.error}, 0);
        check("rst_spi_od", bus.spi_od, 0);
        check("rst_move_num", bus.move_num, 0);
        check("rst_layer_idx", bus.layer_idx, 0);
        rst = 1'b0;
        cyc();

        // Three moves, tie on score 5 resolves to the first move
        g0 = n_grid; l0 = n_layer;
        start_run(8'd3);
        do_move(16'h1111, 8'd5, 0);
        do_move(16'h2222, 8'hfd, 1);
        do_move(16'h3333, 8'd5, 0);
        finish_run(0);
        check("t1_grid_count", n_grid - g0, 3);
        check("t1_layer_count", n_layer - l0, 12);

        // All-negative scores; also a start pulse while busy must be ignored
        start_run(8'd2);
        bus.moves_iv = 1'b1;
        bus.total_move_id = 8'd0;
        do_move(16'h1111, 8'h9c, 1);
        do_move(16'h2222, 8'h80, 0);
        finish_run(0);
        check("t2_no_error", bus.error, 0);

        // Zero moves
        g0 = n_grid;
        start_run(8'd0);
        finish_run(1);
        check("t3_no_grid", n_grid - g0, 0);

        // Count clamped to MAX_MOVES
        g0 = n_grid;
        start_run(8'd250);
        for (int i = 0; i < 220; i++) begin
            do_move(16'h0100 + 16'(i), 8'((i * 37) % 256), i % 2);
        end
        finish_run(0);
        check("t4_grid_count", n_grid - g0, 220);
        check("t4_last_idx", grid_idx, 220);

        // Early score, duplicate ignored, no WAIT_SCORE detour
        start_run(8'd2);
        do_move(16'h4455, 8'd3, 0);
        do_move(16'hA5C3, 8'd7, 2);
        finish_run(0);

`ifdef MOVE_EVAL_TIMEOUT_EN
        // Move 1 never gets a grid; watchdog skips it
        start_run(8'd3);
        do_move(16'h1111, 8'hfb, 0);
        do_move(16'h2222, 8'd100, 3);
        do_move(16'h3333, 8'd9, 1);
        finish_run(0);
        check("t6_error_set", bus.error, 1);
        start_run(8'd0);
        check("t6_error_cleared", bus.error, 0);
        finish_run(1);
`endif

        // Reset in the middle of WAIT_LAYER
        start_run(8'd1);
        cyc();
        bus.grid_iv = 1'b1;
        bus.current_move_id = 16'hbeef;
        cyc();
        bus.grid_iv = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        check("midrst_busy", bus.busy, 0);
        check("midrst_outputs", {bus.compute_grid, bus.layer_start, bus.spi_ov, bus.error}, 0);
        check("midrst_spi_od", bus.spi_od, 0);
        check("midrst_idx", {bus.move_num, bus.layer_idx}, 0);
        rst = 1'b0;
        repeat (5) cyc();
        check("post_rst_idle", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
